// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving
// datapath mux selects, memory handshake strobes and a retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        aluZero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        we,
    output logic        d4,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  d1,
    output logic        d2,
    output logic        d3,
    output logic [5:0]  op,
    output logic        regWr,
    output logic        regMem,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_ADDI = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_BEQ  = 3'd4,
        C_J    = 3'd5
    } class_t;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_HALT = 6'h3F;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;

    state_t      state_q, state_d;
    class_t      class_q, class_d;
    logic [15:0] retired_q;
    logic        run_q;
    logic        retire;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign retired   = retired_q;
    assign state_dbg = state_q;

    // run_q holds off the first fetch request until one clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            class_q   <= C_R;
            retired_q <= 16'h0000;
            run_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            run_q   <= 1'b1;
            if (retire) begin
                retired_q <= retired_q + 16'h0001;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        retire  = 1'b0;
        mem_req = 1'b0;
        we      = 1'b0;
        d4      = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        d1      = 2'b00;
        d2      = 1'b0;
        d3      = 1'b0;
        op      = 6'h00;
        regWr   = 1'b0;
        regMem  = 1'b0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode)
                    OPC_R:    class_d = C_R;
                    OPC_ADDI: class_d = C_ADDI;
                    OPC_LW:   class_d = C_LW;
                    OPC_SW:   class_d = C_SW;
                    OPC_BEQ:  class_d = C_BEQ;
                    OPC_J:    class_d = C_J;
                    OPC_HALT: state_d = S_HALT;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        op      = funct;
                        state_d = S_WB;
                    end
                    C_ADDI: begin
                        op      = ALU_ADD;
                        d2      = 1'b1;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: begin
                        op      = ALU_ADD;
                        d2      = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BEQ: begin
                        op      = ALU_SUB;
                        d1      = 2'b01;
                        pc_we   = aluZero;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default: begin
                        d1      = 2'b10;
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                d4      = 1'b1;
                op      = ALU_ADD;
                d2      = 1'b1;
                we      = (class_q == C_SW);
                if (mem_ack) begin
                    if (class_q == C_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regWr   = 1'b1;
                regMem  = (class_q == C_LW);
                d3      = (class_q == C_R);
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: begin
                halted = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// against hand-computed control vectors.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        aluZero;
  logic        mem_ack;
  logic        mem_req, we, d4, ir_we, pc_we, d2, d3, regWr, regMem, halted, illegal;
  logic [1:0]  d1;
  logic [5:0]  op;
  logic [15:0] retired;
  logic [2:0]  state_dbg;
  logic [18:0] outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .aluZero   (aluZero),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .we        (we),
    .d4        (d4),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .op        (op),
    .regWr     (regWr),
    .regMem    (regMem),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired),
    .state_dbg (state_dbg)
  );

  assign outs = {mem_req, we, d4, ir_we, pc_we, d1, d2, d3, op, regWr, regMem, halted, illegal};

  function automatic logic [18:0] e(input logic mr, input logic w, input logic a4,
                                    input logic irw, input logic pcw, input logic [1:0] sd1,
                                    input logic sd2, input logic sd3, input logic [5:0] sop,
                                    input logic rw, input logic rm, input logic h, input logic il);
    return {mr, w, a4, irw, pcw, sd1, sd2, sd3, sop, rw, rm, h, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later, then one clock passes.
  task automatic cyc(input string tag, input logic [18:0] exp);
    #1;
    chk(tag, {13'b0, outs}, {13'b0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [18:0] E_NONE, E_FREQ, E_FACK, E_EXALU, E_MEM_LD, E_MEM_ST, E_HALT;

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    E_NONE   = '0;
    E_FREQ   = e(1, 0, 0, 0, 0, 2'b00, 0, 0, 6'h00, 0, 0, 0, 0);
    E_FACK   = e(1, 0, 0, 1, 1, 2'b00, 0, 0, 6'h00, 0, 0, 0, 0);
    E_EXALU  = e(0, 0, 0, 0, 0, 2'b00, 1, 0, 6'h20, 0, 0, 0, 0);
    E_MEM_LD = e(1, 0, 1, 0, 0, 2'b00, 1, 0, 6'h20, 0, 0, 0, 0);
    E_MEM_ST = e(1, 1, 1, 0, 0, 2'b00, 1, 0, 6'h20, 0, 0, 0, 0);
    E_HALT   = e(0, 0, 0, 0, 0, 2'b00, 0, 0, 6'h00, 0, 0, 1, 0);

    rst = 1'b0; instr = 32'h0; aluZero = 1'b0; mem_ack = 1'b0;
    #2;
    chk("rst_outs", {13'b0, outs}, 32'h0);
    chk("rst_retired", {16'b0, retired}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("pre_first_clk_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    cyc("idle_fetch", E_FREQ);

    // R-type add, mem_ack tied high: ack ignored outside FETCH
    instr = 32'h0000_0020; mem_ack = 1'b1;
    cyc("r_fetch", E_FACK);
    cyc("r_decode", E_NONE);
    cyc("r_exec", e(0, 0, 0, 0, 0, 2'b00, 0, 0, 6'h20, 0, 0, 0, 0));
    cyc("r_wb", e(0, 0, 0, 0, 0, 2'b00, 0, 1, 6'h00, 1, 0, 0, 0));
    mem_ack = 1'b0;
    #1 chk("r_retired", {16'b0, retired}, 32'd1);
    cyc("r_next_fetch", E_FREQ);

    // ADDI: op forced to add regardless of funct bits
    instr = 32'h2000_0025; mem_ack = 1'b1;
    cyc("addi_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("addi_decode", E_NONE);
    cyc("addi_exec", E_EXALU);
    cyc("addi_wb", e(0, 0, 0, 0, 0, 2'b00, 0, 0, 6'h00, 1, 0, 0, 0));
    #1 chk("addi_retired", {16'b0, retired}, 32'd2);

    // LW with two wait cycles; live instr changed to R after decode
    instr = 32'h8C00_0000; mem_ack = 1'b1;
    cyc("lw_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("lw_decode", E_NONE);
    instr = 32'h0000_0020;
    cyc("lw_exec", E_EXALU);
    cyc("lw_mem_wait1", E_MEM_LD);
    cyc("lw_mem_wait2", E_MEM_LD);
    mem_ack = 1'b1;
    cyc("lw_mem_ack", E_MEM_LD);
    mem_ack = 1'b0;
    cyc("lw_wb", e(0, 0, 0, 0, 0, 2'b00, 0, 0, 6'h00, 1, 1, 0, 0));
    #1 chk("lw_retired", {16'b0, retired}, 32'd3);
    cyc("lw_next_fetch", E_FREQ);

    // SW zero-wait
    instr = 32'hAC00_0000; mem_ack = 1'b1;
    cyc("sw_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("sw_decode", E_NONE);
    cyc("sw_exec", E_EXALU);
    mem_ack = 1'b1;
    cyc("sw_mem_ack", E_MEM_ST);
    mem_ack = 1'b0;
    #1 chk("sw_retired", {16'b0, retired}, 32'd4);

    // BEQ taken then not taken
    instr = 32'h1000_0000; mem_ack = 1'b1; aluZero = 1'b1;
    cyc("beq1_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("beq1_decode", E_NONE);
    cyc("beq1_exec", e(0, 0, 0, 0, 1, 2'b01, 0, 0, 6'h22, 0, 0, 0, 0));
    #1 chk("beq1_retired", {16'b0, retired}, 32'd5);
    aluZero = 1'b0; mem_ack = 1'b1;
    cyc("beq0_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("beq0_decode", E_NONE);
    cyc("beq0_exec", e(0, 0, 0, 0, 0, 2'b01, 0, 0, 6'h22, 0, 0, 0, 0));
    #1 chk("beq0_retired", {16'b0, retired}, 32'd6);

    // J
    instr = 32'h0800_0000; mem_ack = 1'b1;
    cyc("j_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("j_decode", E_NONE);
    cyc("j_exec", e(0, 0, 0, 0, 1, 2'b10, 0, 0, 6'h00, 0, 0, 0, 0));
    #1 chk("j_retired", {16'b0, retired}, 32'd7);

    // Illegal opcode 0x3E
    instr = 32'hF800_0000; mem_ack = 1'b1;
    cyc("ill_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("ill_decode", e(0, 0, 0, 0, 0, 2'b00, 0, 0, 6'h00, 0, 0, 0, 1));
    cyc("ill_back_fetch", E_FREQ);
    #1 chk("ill_retired", {16'b0, retired}, 32'd7);

    // SW interrupted by reset mid-MEM
    instr = 32'hAC00_0000; mem_ack = 1'b1;
    cyc("swr_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("swr_decode", E_NONE);
    cyc("swr_exec", E_EXALU);
    #1 chk("swr_mem_pending", {13'b0, outs}, {13'b0, E_MEM_ST});
    #1 rst = 1'b0;
    #1 chk("swr_outs_async", {13'b0, outs}, 32'h0);
    chk("swr_retired", {16'b0, retired}, 32'h0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    #1 chk("swr_pre_clk_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    cyc("swr_resume", E_FREQ);

    // Counter wrap: preload 0xFFFF, retire one J
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    instr = 32'h0800_0000; mem_ack = 1'b1;
    cyc("wrap_fetch", E_FACK);
    mem_ack = 1'b0;
    cyc("wrap_decode", E_NONE);
    cyc("wrap_exec", e(0, 0, 0, 0, 1, 2'b10, 0, 0, 6'h00, 0, 0, 0, 0));
    #1 chk("wrap_retired", {16'b0, retired}, 32'h0);

    // HALT: level output, mem_ack ignored
    instr = 32'hFC00_0000; mem_ack = 1'b1;
    cyc("halt_fetch", E_FACK);
    cyc("halt_decode", E_NONE);
    cyc("halt_1", E_HALT);
    mem_ack = 1'b0;
    cyc("halt_2", E_HALT);
    mem_ack = 1'b1;
    cyc("halt_3", E_HALT);
    mem_ack = 1'b0;
    cyc("halt_4", E_HALT);
    #1 chk("halt_retired", {16'b0, retired}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock, sole clock.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 instr  input  32  datapath instruction register; opcode instr[31:26], funct instr[5:0].
REQ-004 aluZero  input  1  datapath ALU zero flag.
REQ-005 mem_ack  input  1  memory completes requested access this cycle.
REQ-006 mem_req  output  1  memory access request.
REQ-007 we  output  1  memory write; meaningful only with mem_req=1.
REQ-008 d4  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-009 ir_we, pc_we  output  1 each  instruction register / PC load strobes.
REQ-010 d1  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 d2, d3  output  1 each  ALU B source (0 reg, 1 imm); register destination (0 rt, 1 rd).
REQ-012 op  output  6  ALU operation code.
REQ-013 regWr, regMem  output  1 each  register-file write strobe; writeback source (0 ALU, 1 memory).
REQ-014 halted, illegal  output  1 each  HALT reached (level); unknown opcode (1-cycle pulse).
REQ-015 retired  output  16  count of completed instructions.

Function
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; strobes not listed for a state SHALL be 0; d1 = 00, d2 = d3 = d4 = 0 and op = 0 unless stated.
REQ-017 FETCH: mem_req = 1, d4 = 0, we = 0 held until mem_ack; in the mem_ack cycle ir_we = 1, pc_we = 1, d1 = 00 (combinational on mem_ack); next state DECODE.
REQ-018 DECODE: no strobes; opcode class latched in a class register; 0x00 R, 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J go to EXEC; 0x3F goes to HALT; any other opcode pulses illegal for this cycle and returns to FETCH.
REQ-019 EXEC, R: op = funct, d2 = 0, then WB. ADDI: op = 0x20, d2 = 1, then WB. LW/SW: op = 0x20, d2 = 1, then MEM.
REQ-020 EXEC, BEQ: op = 0x22, d2 = 0, d1 = 01, pc_we = aluZero; then FETCH. J: d1 = 10, pc_we = 1; then FETCH.
REQ-021 MEM: mem_req = 1, d4 = 1, op = 0x20, d2 = 1, we = 1 for SW only; held until mem_ack; on ack SW goes to FETCH and LW goes to WB.
REQ-022 WB: regWr = 1 for exactly one cycle; regMem = 1 for LW; d3 = 1 for R, 0 for ADDI/LW; then FETCH.
REQ-023 HALT: halted = 1, all strobes 0, remains until reset; mem_ack ignored.
REQ-024 mem_ack outside FETCH/MEM SHALL be ignored; mem_req SHALL deassert the cycle after the ack cycle, with no gap-free re-request unless the next state requests.
REQ-025 Cycle counts at zero-wait memory: R/ADDI/SW 4, LW 5, BEQ/J 3, each wait cycle adds 1.
REQ-026 retired SHALL increment by 1 on each transition to FETCH from EXEC, MEM or WB, not on illegal; wraps 0xFFFF -> 0x0000.
REQ-027 Decisions in EXEC/MEM/WB SHALL use the latched class, not live instr.

Reset
REQ-028 rst = 0 SHALL immediately force state FETCH, retired = 0, class = R, and all outputs 0 except mem_req, which is asserted from the first clock after rst deassertion.
REQ-029 Reset during a pending MEM access SHALL drop mem_req and we asynchronously; no register write occurs.

Verification
REQ-030 R-type add (funct 0x20), mem_ack tied 1 -> mem_req/ir_we/pc_we at cycle 0, op = 0x20 at cycle 2, regWr = 1, d3 = 1 at cycle 3, retired 0 -> 1.
REQ-031 LW with mem_ack delayed 2 cycles in MEM -> d4 = 1, we = 0 held 3 cycles, then WB with regMem = 1; total 7 cycles.
REQ-032 BEQ with aluZero = 1 then aluZero = 0 -> pc_we = 1, d1 = 01 in the first EXEC; pc_we = 0 in the second; both take 3 cycles.
REQ-033 opcode 0x3E -> illegal pulse in DECODE, back in FETCH next cycle, retired unchanged; opcode 0x3F -> halted = 1 persists, and mem_ack pulses give no response.
REQ-034 SW with rst asserted mid-MEM -> mem_req = 0 and we = 0 same cycle, retired = 0; after release, FETCH request resumes.
REQ-035 Preload by running 65535 instructions, then one more -> retired wraps to 0x0000.
